async_reset_reg_pipe: RTL and testbench
=======================================

ASYNC_RESET_REG_PIPE -- requirements
Module: async_reset_reg_pipe

Interface
REQ-001: Parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-002: Parameter DEPTH, default 3, number of register stages; legal range 1..16.
REQ-003: Parameter RESET_VAL, WIDTH bits, default all-zero, value loaded into every stage on reset or flush.
REQ-004: clk  input  1  clock; all state updates on the rising edge.
REQ-005: rst  input  1  reset; asynchronous, active-high.
REQ-006: en  input  1  shift enable; when high, every stage advances one position.
REQ-007: flush  input  1  synchronous flush; reloads every stage to RESET_VAL.
REQ-008: d  input  WIDTH  data into stage 0.
REQ-009: q  output  WIDTH  data from the last stage (stage DEPTH-1), taken straight from a register.
REQ-010: valid  output  1  high when every stage holds data shifted in since the last reset or flush.
REQ-011: parity_err  output  1  parity mismatch on q; the port is always present.

Function
REQ-012: On a clock edge with en=1 and flush=0, stage 0 SHALL load d and stage i SHALL load stage i-1, for i = 1..DEPTH-1.
REQ-013: On a clock edge with en=0 and flush=0, all stages and the fill counter SHALL hold.
REQ-014: Latency from d to q SHALL be exactly DEPTH enabled edges, and no combinational path from d to q is allowed.
REQ-015: flush=1 SHALL take priority over en.
REQ-016: On a flush edge, all stages SHALL load RESET_VAL and the fill counter SHALL clear to 0.
REQ-017: The fill counter SHALL be $clog2(DEPTH+1) bits wide.
REQ-018: The fill counter SHALL increment on each edge with en=1 and flush=0, and saturate at DEPTH with no wrap-around.
REQ-019: valid SHALL equal (fill counter == DEPTH) and is a registered-state decode.
REQ-020: With DEPTH=1, valid SHALL rise one enabled edge after reset or flush.
REQ-021: en and d SHALL have no effect while rst=1.

Reset
REQ-022: While rst=1, every stage SHALL be RESET_VAL, the fill counter 0, valid 0 and parity_err 0, independent of clk.
REQ-023: Reset asserted mid-operation SHALL clear all state immediately and asynchronously, without waiting for a clock edge.
REQ-024: The first enabled edge after rst deasserts SHALL behave exactly as in REQ-012.
REQ-025: Synchronisation of reset deassertion is the integrator's responsibility and is outside this block.

Configuration
REQ-026: With macro ASYNC_RESET_REG_PIPE_PARITY_EN defined, each stage SHALL carry one extra parity bit alongside its data.
REQ-027: Stage 0 parity SHALL load ^d; the parity bit SHALL shift, hold and flush with its data.
REQ-028: The parity bit SHALL reset and flush to ^RESET_VAL.
REQ-029: With the macro defined, parity_err SHALL equal (^q) XOR (last-stage parity bit), combinational from registers.
REQ-030: Without the macro, no parity storage SHALL exist and parity_err SHALL be tied to 0.

Structure
REQ-031: Package async_reset_reg_pkg SHALL hold the MAX_WIDTH (64) and MAX_DEPTH (16) constants.
REQ-032: Package async_reset_reg_pkg SHALL hold the fill-counter width function, which returns 1 minimum.
REQ-033: One sub-module, async_reset_reg_stage, SHALL implement a single WIDTH-bit stage with en, flush, rst and RESET_VAL, plus the optional parity bit.
REQ-034: The top level SHALL instantiate DEPTH copies of async_reset_reg_stage in a generate loop.
REQ-035: The top level SHALL own the fill counter and the valid and parity_err logic.
REQ-036: Out-of-range WIDTH or DEPTH SHALL cause an elaboration-time error.

Verification (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5)
REQ-037: Reset mid-stream -> assert rst between clock edges; q=8'hA5 and valid=0 immediately, before the next edge.
REQ-038: Latency -> after reset, en=1 with d=11,22,33 on three edges; q=8'h11 and valid=1 after the third edge.
REQ-039: Hold and saturation -> en=0 for 5 edges leaves q and valid unchanged; 10 further enabled edges keep valid=1 with no counter wrap.
REQ-040: Flush versus enable -> flush=1 and en=1 with d=8'h77 on the same edge; q=8'hA5, valid=0, and 8'h77 never appears on q.
REQ-041: Parity (macro defined) -> force the last-stage parity bit inverted; parity_err=1 at once, then 0 after the next enabled edge that loads clean data. Without the macro, parity_err=0 at all times.
REQ-042: Gated shift -> en=1 on alternate cycles with d=01,02,03,04; q shows 01 only after the third enabled edge, and valid tracks enabled edges, not cycles.

Source files
------------

// File: rtl/async_reset_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : async_reset_reg_pkg
// Brief    : Shared limits and helpers for the async-reset register pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package async_reset_reg_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_DEPTH = 16;

    // Counter must represent 0..depth inclusive; never narrower than one bit.
    function automatic int fill_cnt_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : async_reset_reg_pkg
`default_nettype wire

// File: rtl/async_reset_reg_stage.sv
`default_nettype none
// ============================================================================
// Module   : async_reset_reg_stage
// Brief    : One WIDTH-bit pipeline register with async reset, sync flush and
//            enable; carries a parity bit when ASYNC_RESET_REG_PIPE_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module async_reset_reg_stage
    import async_reset_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
    input  logic             d_par,
    output logic             q_par,
`endif
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("async_reset_reg_stage: WIDTH out of range");
        end
    endgenerate

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= RESET_VAL;
        end else if (flush) begin
            r_data <= RESET_VAL;
        end else if (en) begin
            r_data <= d;
        end
    end

    assign q = r_data;

`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
    localparam logic c_reset_par = ^RESET_VAL;

    logic r_par;

    // Parity follows exactly the same load/hold/flush rules as its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= c_reset_par;
        end else if (flush) begin
            r_par <= c_reset_par;
        end else if (en) begin
            r_par <= d_par;
        end
    end

    assign q_par = r_par;
`endif

endmodule : async_reset_reg_stage
`default_nettype wire

// File: rtl/async_reset_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : async_reset_reg_pipe
// Brief    : DEPTH-stage register pipeline with async reset, sync flush, fill
//            tracking and optional per-stage parity (ASYNC_RESET_REG_PIPE_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module async_reset_reg_pipe
    import async_reset_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             parity_err
);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("async_reset_reg_pipe: WIDTH out of range");
        end
        if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
            $error("async_reset_reg_pipe: DEPTH out of range");
        end
    endgenerate

    localparam int                 c_cnt_w = fill_cnt_width(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [WIDTH-1:0] w_stage_q [DEPTH];
`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
    logic [DEPTH-1:0] w_stage_par;
`endif

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic [WIDTH-1:0] w_d;
`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
            logic             w_d_par;
`endif
            if (i == 0) begin : g_head
                assign w_d = d;
`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
                assign w_d_par = ^d;
`endif
            end else begin : g_chain
                assign w_d = w_stage_q[i-1];
`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
                assign w_d_par = w_stage_par[i-1];
`endif
            end

            async_reset_reg_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .flush (flush),
                .d     (w_d),
`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
                .d_par (w_d_par),
                .q_par (w_stage_par[i]),
`endif
                .q     (w_stage_q[i])
            );
        end
    endgenerate

    // Fill counter saturates at DEPTH so valid stays high under continuous shifting.
    logic [c_cnt_w-1:0] r_fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else if (flush) begin
            r_fill <= '0;
        end else if (en && (r_fill != c_depth)) begin
            r_fill <= r_fill + c_one;
        end
    end

    assign q     = w_stage_q[DEPTH-1];
    assign valid = (r_fill == c_depth);

`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
    assign parity_err = (^w_stage_q[DEPTH-1]) ^ w_stage_par[DEPTH-1];
`else
    assign parity_err = 1'b0;
`endif

endmodule : async_reset_reg_pipe
`default_nettype wire

// File: tb/tb_async_reset_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_reset_reg_pipe
// Brief    : Directed self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_reset_reg_pipe;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 3;
    localparam logic [7:0] RESET_VAL = 8'hA5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             parity_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit forcing = 1'b0;

    async_reset_reg_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .d          (d),
        .q          (q),
        .valid      (valid),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Reference: a history of values pushed since the last clear; q is the
    // value pushed DEPTH pushes ago, valid once DEPTH pushes have happened.
    logic [WIDTH-1:0] hist [$];

    always @(posedge clk or posedge rst) begin
        if (rst || flush) hist.delete();
        else if (en) hist.push_back(d);
    end

    function automatic logic [WIDTH-1:0] exp_q();
        if (hist.size() >= DEPTH) return hist[hist.size() - DEPTH];
        return RESET_VAL;
    endfunction

    function automatic logic exp_valid();
        return hist.size() >= DEPTH;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", q, exp_q());
            check("model_valid", valid, exp_valid());
            if (!forcing) check("model_parity_err", parity_err, 1'b0);
        end
    end

    task automatic step(input logic e, input logic f, input logic [WIDTH-1:0] v);
        en = e;
        flush = f;
        d = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_q", q, RESET_VAL);
        check("reset_valid", valid, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 8'hEE);
        check("reset_ignores_en_q", q, RESET_VAL);
        rst = 1'b0;

        // Latency
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        check("latency_pre_valid", valid, 1'b0);
        check("latency_pre_q", q, RESET_VAL);
        step(1'b1, 1'b0, 8'h33);
        check("latency_q", q, 8'h11);
        check("latency_valid", valid, 1'b1);

        // Hold then saturation
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'hFF);
        check("hold_q", q, 8'h11);
        check("hold_valid", valid, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
        check("sat_q", q, 8'h47);
        check("sat_valid", valid, 1'b1);

        // Flush beats enable; 77 must never surface
        step(1'b1, 1'b1, 8'h77);
        check("flush_q", q, RESET_VAL);
        check("flush_valid", valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check("flush_no_77", {7'd0, q == 8'h77}, 64'd0);
        end

        // Gated shift on alternate cycles
        step(1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 8'h99);
        step(1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b0, 8'h99);
        check("gated_q_after2", q, RESET_VAL);
        check("gated_valid_after2", valid, 1'b0);
        step(1'b1, 1'b0, 8'h03);
        check("gated_q_after3", q, 8'h01);
        check("gated_valid_after3", valid, 1'b1);
        step(1'b0, 1'b0, 8'h99);
        step(1'b1, 1'b0, 8'h04);
        check("gated_q_after4", q, 8'h02);

`ifdef ASYNC_RESET_REG_PIPE_PARITY_EN
        begin
            logic p;
            p = dut.g_stage[DEPTH-1].u_stage.r_par;
            forcing = 1'b1;
            force dut.g_stage[DEPTH-1].u_stage.r_par = ~p;
            #1;
            check("parity_forced", parity_err, 1'b1);
            release dut.g_stage[DEPTH-1].u_stage.r_par;
            #1;
            check("parity_held_after_release", parity_err, 1'b1);
            step(1'b1, 1'b0, 8'h05);
            forcing = 1'b0;
            check("parity_cleared", parity_err, 1'b0);
        end
`endif

        // Reset mid-stream between edges, then first edge after release
        step(1'b1, 1'b0, 8'h06);
        rst = 1'b1;
        #1;
        check("midreset_q", q, RESET_VAL);
        check("midreset_valid", valid, 1'b0);
        check("midreset_parity_err", parity_err, 1'b0);
        step(1'b1, 1'b0, 8'hEE);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h5A);
        check("post_reset_first_q", q, RESET_VAL);
        check("post_reset_first_valid", valid, 1'b0);
        step(1'b1, 1'b0, 8'h6B);
        step(1'b1, 1'b0, 8'h7C);
        check("post_reset_q", q, 8'h5A);
        check("post_reset_valid", valid, 1'b1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_async_reset_reg_pipe
`default_nettype wire
